// File: rtl/decode_execute_unit.sv
// Single-stage decode + execute: opcode decode, immediate sign extension,
// operand select and add/sub ALU, with every output registered once per clock.
module decode_execute_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    output logic        reg_write,
    output logic        reg_dest,
    output logic        alu_src,
    output logic        branch,
    output logic        mem_to_reg,
    output logic        mem_write,
    output logic        mem_read,
    output logic        jump,
    output logic        alu_op,
    output logic [4:0]  write_reg_addr,
    output logic [31:0] imm_ext,
    output logic [31:0] alu_result,
    output logic        alu_zero
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_t;

    logic [5:0]  w_opcode;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic        w_reg_write;
    logic        w_reg_dest;
    logic        w_alu_src;
    logic        w_branch;
    logic        w_mem_to_reg;
    logic        w_mem_write;
    logic        w_mem_read;
    logic        w_jump;
    logic        w_alu_op;
    logic [4:0]  w_write_reg_addr;
    logic [31:0] w_imm_ext;
    logic [31:0] w_operand_b;
    logic [31:0] w_alu_result;

    logic        r_reg_write;
    logic        r_reg_dest;
    logic        r_alu_src;
    logic        r_branch;
    logic        r_mem_to_reg;
    logic        r_mem_write;
    logic        r_mem_read;
    logic        r_jump;
    logic        r_alu_op;
    logic [4:0]  r_write_reg_addr;
    logic [31:0] r_imm_ext;
    logic [31:0] r_alu_result;
    logic        r_alu_zero;

    assign w_opcode = instr[31:26];
    assign w_rt     = instr[20:16];
    assign w_rd     = instr[15:11];

    // Funct bits are deliberately ignored: R-type always adds.
    always_comb begin
        w_reg_write  = 1'b0;
        w_reg_dest   = 1'b0;
        w_alu_src    = 1'b0;
        w_branch     = 1'b0;
        w_mem_to_reg = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_jump       = 1'b0;
        w_alu_op     = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                w_reg_write = 1'b1;
                w_reg_dest  = 1'b1;
            end
            OP_LW: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_mem_to_reg = 1'b1;
                w_mem_read   = 1'b1;
            end
            OP_SW: begin
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            OP_BEQ: begin
                w_branch = 1'b1;
                w_alu_op = 1'b1;
            end
            OP_ADDI: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            OP_J: begin
                w_jump = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign w_write_reg_addr = w_reg_dest ? w_rd : w_rt;
    assign w_imm_ext        = {{16{instr[15]}}, instr[15:0]};
    assign w_operand_b      = w_alu_src ? w_imm_ext : rdata2;
    assign w_alu_result     = w_alu_op ? (rdata1 - w_operand_b) : (rdata1 + w_operand_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg_write      <= 1'b0;
            r_reg_dest       <= 1'b0;
            r_alu_src        <= 1'b0;
            r_branch         <= 1'b0;
            r_mem_to_reg     <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_read       <= 1'b0;
            r_jump           <= 1'b0;
            r_alu_op         <= 1'b0;
            r_write_reg_addr <= '0;
            r_imm_ext        <= '0;
            r_alu_result     <= '0;
            r_alu_zero       <= 1'b0;
        end else begin
            r_reg_write      <= w_reg_write;
            r_reg_dest       <= w_reg_dest;
            r_alu_src        <= w_alu_src;
            r_branch         <= w_branch;
            r_mem_to_reg     <= w_mem_to_reg;
            r_mem_write      <= w_mem_write;
            r_mem_read       <= w_mem_read;
            r_jump           <= w_jump;
            r_alu_op         <= w_alu_op;
            r_write_reg_addr <= w_write_reg_addr;
            r_imm_ext        <= w_imm_ext;
            r_alu_result     <= w_alu_result;
            r_alu_zero       <= (w_alu_result == '0);
        end
    end

    assign reg_write      = r_reg_write;
    assign reg_dest       = r_reg_dest;
    assign alu_src        = r_alu_src;
    assign branch         = r_branch;
    assign mem_to_reg     = r_mem_to_reg;
    assign mem_write      = r_mem_write;
    assign mem_read       = r_mem_read;
    assign jump           = r_jump;
    assign alu_op         = r_alu_op;
    assign write_reg_addr = r_write_reg_addr;
    assign imm_ext        = r_imm_ext;
    assign alu_result     = r_alu_result;
    assign alu_zero       = r_alu_zero;

endmodule

// File: tb/tb_decode_execute_unit.sv
// Self-checking bench for decode_execute_unit: directed vectors, randomized
// traffic against a behavioural model, edge-only sampling and async reset.
module tb_decode_execute_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        reg_write, reg_dest, alu_src, branch;
    logic        mem_to_reg, mem_write, mem_read, jump, alu_op;
    logic [4:0]  write_reg_addr;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [78:0] obs;

    int checks = 0;
    int errors = 0;

    decode_execute_unit dut (
        .clk            (clk),
        .rst            (rst),
        .instr          (instr),
        .rdata1         (rdata1),
        .rdata2         (rdata2),
        .reg_write      (reg_write),
        .reg_dest       (reg_dest),
        .alu_src        (alu_src),
        .branch         (branch),
        .mem_to_reg     (mem_to_reg),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .jump           (jump),
        .alu_op         (alu_op),
        .write_reg_addr (write_reg_addr),
        .imm_ext        (imm_ext),
        .alu_result     (alu_result),
        .alu_zero       (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {reg_write, reg_dest, alu_src, branch, mem_to_reg, mem_write,
                  mem_read, jump, alu_op, write_reg_addr, imm_ext, alu_result, alu_zero};

    // Expected output bundle for one instruction, same bit order as obs.
    function automatic logic [78:0] model(input logic [31:0] ins, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [5:0]  op;
        logic        rw, rdst, src, br, m2r, mw, mr, jmp, sub;
        logic [31:0] ext, opb, res;
        logic [4:0]  dst;
        op = ins[31:26];
        rw = 0; rdst = 0; src = 0; br = 0; m2r = 0; mw = 0; mr = 0; jmp = 0; sub = 0;
        if (op == 6'd0)       begin rw = 1; rdst = 1; end
        else if (op == 6'd35) begin rw = 1; src = 1; m2r = 1; mr = 1; end
        else if (op == 6'd43) begin src = 1; mw = 1; end
        else if (op == 6'd4)  begin br = 1; sub = 1; end
        else if (op == 6'd8)  begin rw = 1; src = 1; end
        else if (op == 6'd2)  jmp = 1;
        ext = 32'($signed(ins[15:0]));
        opb = src ? ext : b;
        res = sub ? a - opb : a + opb;
        dst = rdst ? ins[15:11] : ins[20:16];
        return {rw, rdst, src, br, m2r, mw, mr, jmp, sub, dst, ext, res, (res == 32'd0)};
    endfunction

    task automatic apply(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        instr = ins; rdata1 = a; rdata2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        instr = $urandom; rdata1 = $urandom; rdata2 = $urandom;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 79'd0) begin
            errors++;
            $display("FAIL reset_initial got=%h exp=0", obs);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 79'd0) begin
            errors++;
            $display("FAIL reset_held_over_edge got=%h exp=0", obs);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        apply({6'b000000, 5'd0, 5'd3, 5'd5, 11'd0}, 32'd7, 32'd8);
        checks++;
        if (alu_result !== 32'd15 || write_reg_addr !== 5'd5 || reg_write !== 1'b1 ||
            reg_dest !== 1'b1 || alu_zero !== 1'b0) begin
            errors++;
            $display("FAIL rtype got res=%h wa=%0d rw=%b rd=%b z=%b exp res=f wa=5 rw=1 rd=1 z=0",
                     alu_result, write_reg_addr, reg_write, reg_dest, alu_zero);
        end
        apply({6'b100011, 5'd0, 5'd9, 16'hFFFC}, 32'h100, $urandom);
        checks++;
        if (imm_ext !== 32'hFFFFFFFC || alu_result !== 32'hFC || write_reg_addr !== 5'd9 ||
            mem_read !== 1'b1 || mem_to_reg !== 1'b1) begin
            errors++;
            $display("FAIL lw got ext=%h res=%h wa=%0d mr=%b m2r=%b exp ext=fffffffc res=fc wa=9 mr=1 m2r=1",
                     imm_ext, alu_result, write_reg_addr, mem_read, mem_to_reg);
        end
        apply({6'b000100, 26'h0}, 32'h12345678, 32'h12345678);
        checks++;
        if (alu_result !== 32'd0 || alu_zero !== 1'b1 || branch !== 1'b1) begin
            errors++;
            $display("FAIL beq_equal got res=%h z=%b br=%b exp res=0 z=1 br=1",
                     alu_result, alu_zero, branch);
        end
        apply({6'b000100, 26'h0}, 32'h12345678, 32'h12345679);
        checks++;
        if (alu_result !== 32'hFFFFFFFF || alu_zero !== 1'b0) begin
            errors++;
            $display("FAIL beq_unequal got res=%h z=%b exp res=ffffffff z=0", alu_result, alu_zero);
        end
        apply({6'b101011, 10'd0, 16'h7FFF}, 32'hFFFF8001, $urandom);
        checks++;
        if (alu_result !== 32'd0 || alu_zero !== 1'b1 || mem_write !== 1'b1 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL sw_wrap got res=%h z=%b mw=%b rw=%b exp res=0 z=1 mw=1 rw=0",
                     alu_result, alu_zero, mem_write, reg_write);
        end
        apply({6'b111111, 26'h3FFFFFF}, 32'd100, 32'd23);
        checks++;
        if (obs[78:70] !== 9'd0 || alu_result !== 32'd123) begin
            errors++;
            $display("FAIL undefined_op got ctl=%b res=%h exp ctl=0 res=7b", obs[78:70], alu_result);
        end
        apply({6'b000010, 26'h1234567}, 32'hFFFFFFFF, 32'd1);
        checks++;
        if (obs[78:70] !== 9'b000000010 || alu_result !== 32'd0 || alu_zero !== 1'b1) begin
            errors++;
            $display("FAIL jump got ctl=%b res=%h z=%b exp ctl=000000010 res=0 z=1",
                     obs[78:70], alu_result, alu_zero);
        end
        apply({6'b001000, 5'd1, 5'd2, 16'h8000}, 32'h8000, 32'd5);
        checks++;
        if (obs !== model({6'b001000, 5'd1, 5'd2, 16'h8000}, 32'h8000, 32'd5) || alu_result !== 32'd0) begin
            errors++;
            $display("FAIL addi_negimm got=%h res=%h exp res=0", obs, alu_result);
        end
    endtask

    task automatic test_random();
        logic [5:0]  ops [7];
        logic [31:0] ins, a, b;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
        for (int i = 0; i < 300; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) != 0) ins[31:26] = ops[$urandom_range(0, 5)];
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? a : $urandom;
            apply(ins, a, b);
            checks++;
            if (obs !== model(ins, a, b)) begin
                errors++;
                $display("FAIL random[%0d] ins=%h a=%h b=%h got=%h exp=%h",
                         i, ins, a, b, obs, model(ins, a, b));
            end
        end
    endtask

    // Inputs wiggle inside the cycle; only the values present at the edge count.
    task automatic test_back_to_back();
        logic [31:0] ins, a, b;
        for (int i = 0; i < 40; i++) begin
            instr = $urandom; rdata1 = $urandom; rdata2 = $urandom;
            #2;
            ins = $urandom; a = $urandom; b = $urandom;
            ins[31:26] = (i % 2 == 0) ? 6'b000100 : 6'b100011;
            instr = ins; rdata1 = a; rdata2 = b;
            @(posedge clk);
            #1;
            checks++;
            if (obs !== model(ins, a, b)) begin
                errors++;
                $display("FAIL back_to_back[%0d] got=%h exp=%h", i, obs, model(ins, a, b));
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] ins, a, b;
        apply({6'b000000, 5'd1, 5'd2, 5'd3, 11'd0}, 32'd1, 32'd2);
        ins = {6'b001000, 5'd4, 5'd6, 16'h0010};
        a = 32'h20; b = $urandom;
        @(negedge clk);
        instr = ins; rdata1 = a; rdata2 = b;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 79'd0) begin
            errors++;
            $display("FAIL reset_async_midop got=%h exp=0", obs);
        end
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== model(ins, a, b) || alu_result !== 32'h30) begin
            errors++;
            $display("FAIL first_capture_after_reset got=%h exp=%h", obs, model(ins, a, b));
        end
    endtask

    initial begin
        rst = 1'b1;
        instr = '0; rdata1 = '0; rdata2 = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
